gates_bist_checker: RTL

- Synthesizable built-in self-test controller for the 64-bit bitwise units xor_64bit, or_64bit and and_64bit in the ALU.
- Drives walking-one operand patterns into the three units and checks their c outputs against computed expectations.
- Reports pass/fail, the first failing vector, which units failed, and the number of failing vectors.

---
 rtl/gates_bist_checker.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/gates_bist_checker.sv
// Built-in self-test controller for the 64-bit xor/or/and gate units.
// Walks a one-hot operand against b=0 and b=all-ones and checks every unit result.
module gates_bist_checker #(
  parameter int unsigned W            = 64,
  parameter int unsigned SETTLE       = 1,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [W-1:0]            a_o,
  output logic [W-1:0]            b_o,
  input  logic [W-1:0]            cxor_i,
  input  logic [W-1:0]            cor_i,
  input  logic [W-1:0]            cand_i,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [$clog2(W):0]      fail_index,
  output logic [2:0]              fail_mask,
  output logic [7:0]              err_cnt
);

  localparam int unsigned IW = $clog2(W);
  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam int unsigned EW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            phase_q, phase_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_d, b_d;
  logic            busy_d, done_d, pass_d;
  logic [IW:0]     fidx_d;
  logic [2:0]      fmask_d;
  logic [EW-1:0]   err_d;

  // Expected unit results for the vector currently on the operand bus
  logic [W-1:0]    onehot_c, exp_xor_c, exp_or_c, exp_and_c;
  logic [2:0]      miss_c;
  logic            last_c, wrap_c, finish_c;
  logic [IW-1:0]   nxt_idx_c;
  logic            nxt_phase_c;

  always_comb begin
    onehot_c    = W'(1) << idx_q;
    exp_xor_c   = phase_q ? ~onehot_c : onehot_c;
    exp_or_c    = phase_q ? {W{1'b1}} : onehot_c;
    exp_and_c   = phase_q ? onehot_c : {W{1'b0}};
    miss_c      = {cand_i != exp_and_c, cor_i != exp_or_c, cxor_i != exp_xor_c};
    wrap_c      = (idx_q == IW'(W - 1));
    last_c      = phase_q && wrap_c;
    nxt_idx_c   = idx_q + IW'(1);
    nxt_phase_c = phase_q | wrap_c;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_o;
    b_d      = b_o;
    busy_d   = busy;
    done_d   = done;
    pass_d   = pass;
    fidx_d   = fail_index;
    fmask_d  = fail_mask;
    err_d    = err_cnt;
    finish_c = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d   = '0;
          fidx_d  = '0;
          fmask_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          phase_d = 1'b0;
          idx_d   = '0;
          a_d     = W'(1);
          b_d     = '0;
          cnt_d   = CW'(SETTLE);
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (|miss_c) begin
          if (err_cnt != {EW{1'b1}}) err_d = err_cnt + EW'(1);
          if (err_cnt == '0) begin
            fidx_d  = {phase_q, idx_q};
            fmask_d = miss_c;
          end
          if (STOP_ON_FAIL) finish_c = 1'b1;
        end
        if (last_c) finish_c = 1'b1;
        if (finish_c) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          a_d     = '0;
          b_d     = '0;
        end else begin
          phase_d = nxt_phase_c;
          idx_d   = nxt_idx_c;
          a_d     = W'(1) << nxt_idx_c;
          b_d     = nxt_phase_c ? {W{1'b1}} : {W{1'b0}};
          cnt_d   = CW'(SETTLE);
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      a_o        <= '0;
      b_o        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_index <= '0;
      fail_mask  <= '0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      a_o        <= a_d;
      b_o        <= b_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      fail_index <= fidx_d;
      fail_mask  <= fmask_d;
      err_cnt    <= err_d;
    end
  end

endmodule
